// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// fifo_arb_pkg : shared types and constants for the FIFO port arbiters
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage : fifo_arb_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin search, first set bit at or after ptr
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  int             cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      // ptr is always below N, so one subtraction is enough to wrap
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin burst-holding arbiter for the FIFO write port
// Optional macro ARB_STATS_EN builds per-requester saturating beat counters.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW       = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [N*WIDTH-1:0]  req_data,
  output logic [N-1:0]        req_ready,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [WIDTH-1:0]    fifo_wr_data,
  output logic [IDW-1:0]      grant_id,
  output logic                busy,
  output logic [N*STAT_W-1:0] stat_beats
);

  localparam int            BCW       = 8;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           xfer;
  logic           holder_valid;
  logic [IDW-1:0] next_ptr;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id_q == IDW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign holder_valid = req_valid[grant_id_q];
  assign xfer         = (state_q == BURST) && holder_valid && !fifo_full;
  assign next_ptr     = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state_q == BURST && !fifo_full) req_ready[grant_id_q] = 1'b1;
  end

  assign fifo_wr      = xfer;
  assign fifo_wr_data = xfer ? sel_data : '0;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q == BURST);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // Dropping valid ends the grant even while the FIFO is full
        if (!holder_valid || (xfer && beat_cnt_q == LAST_BEAT)) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef ARB_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_stat
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (xfer && grant_id_q == IDW'(i) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end

    assign stat_beats[i*STAT_W +: STAT_W] = cnt_q;
  end
`else
  assign stat_beats = '0;
`endif

endmodule : fifo_wr_arbiter

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// tb_fifo_wr_arbiter : directed and random checks against a behavioural model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wr;
  logic [W-1:0]  fifo_wr_data;
  logic [1:0]    grant_id;
  logic          busy;
  logic [63:0]   stat_beats;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the port, how many beats it has taken,
  // where the next search starts, and per-source data sequence numbers.
  int m_owner = -1;
  int m_beats = 0;
  int m_rr    = 0;
  int seq  [N];
  int mstat[N];
  int dut_wr_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'((i << 6) | (seq[i] & 63));
  end

  fifo_wr_arbiter #(
    .N         (N),
    .WIDTH     (W),
    .MAX_BURST (MB),
    .IDW       (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .stat_beats   (stat_beats)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_stat();
`ifdef ARB_STATS_EN
    return {16'(mstat[3]), 16'(mstat[2]), 16'(mstat[1]), 16'(mstat[0])};
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [7:0] src(input int g);
    return 8'((g << 6) | (seq[g] & 63));
  endfunction

  task automatic chk_rst();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_data", fifo_wr_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_stat", stat_beats, 0);
  endtask

  // One cycle: inputs already set in the low phase; check, clock, update model.
  task automatic step();
    int  g;
    bit  xf;
    logic [3:0] er;
    #1;
    g  = m_owner;
    xf = (g >= 0) && req_valid[g] && !fifo_full;
    er = (g >= 0 && !fifo_full) ? 4'(1 << g) : 4'd0;
    chk("busy", busy, (g >= 0));
    if (g >= 0) chk("grant_id", grant_id, g);
    chk("req_ready", req_ready, er);
    chk("fifo_wr", fifo_wr, xf);
    chk("wr_data", fifo_wr_data, xf ? src(g) : 8'd0);
    chk("stat", stat_beats, exp_stat());
    if (fifo_wr) dut_wr_cnt++;
    @(posedge clk);
    if (g < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req_valid[(m_rr + k) % N]) begin
          m_owner = (m_rr + k) % N;
          m_beats = 0;
        end
      end
    end else begin
      if (xf) begin
        seq[g]++;
        m_beats++;
        if (mstat[g] < 65535) mstat[g]++;
      end
      if (!req_valid[g] || (xf && m_beats == MB)) begin
        m_owner = -1;
        m_rr    = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (m_owner < 0 && n < 20) begin
      step();
      n++;
    end
    #1;
    chk("grant_wait", busy, 1);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0;
    fifo_full = 1'b0;
    while (m_owner >= 0 && n < 20) begin
      step();
      n++;
    end
    step();
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int cnt;
    for (int i = 0; i < N; i++) begin
      seq[i]   = 0;
      mstat[i] = 0;
    end
    rst       = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_rst();
    rst = 1'b1;
    @(negedge clk);

    // All four requesters: grant order and 4-beat bursts
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_busy();
      chk("rr_order", grant_id, exp_order[k]);
      repeat (MB) step();
    end
    req_valid = '0;
    step();

    // Single requester 2 streaming: 10 writes in 12 cycles after first grant
    req_valid = 4'b0100;
    wait_busy();
    chk("single_gid", grant_id, 2);
    dut_wr_cnt = 0;
    repeat (12) step();
    chk("single_writes", dut_wr_cnt, 10);
    drain();

    // Full stall during beat 2 of requester 1
    req_valid = 4'b0010;
    wait_busy();
    chk("stall_gid", grant_id, 1);
    dut_wr_cnt = 0;
    step();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_wr", fifo_wr, 0);
      chk("stall_ready", req_ready, 0);
      chk("stall_gid_hold", grant_id, 1);
      step();
    end
    fifo_full = 1'b0;
    cnt = 0;
    while (m_owner >= 0 && cnt < 20) begin
      step();
      cnt++;
    end
    chk("stall_beats", dut_wr_cnt, 4);
    drain();

    // Early release by requester 3 while requester 0 waits
    req_valid = 4'b1000;
    wait_busy();
    chk("early_gid3", grant_id, 3);
    req_valid = 4'b1001;
    repeat (2) step();
    req_valid = 4'b0001;
    step();
    #1;
    chk("early_idle", busy, 0);
    step();
    #1;
    chk("early_gid0", grant_id, 0);
    chk("early_busy", busy, 1);
    drain();

    // Asynchronous reset in beat 3 of requester 2
    req_valid = 4'b0100;
    wait_busy();
    repeat (2) step();
    #3;
    rst = 1'b0;
    #1;
    chk_rst();
    m_owner = -1;
    m_rr    = 0;
    for (int i = 0; i < N; i++) mstat[i] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_rst();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b1111;
    wait_busy();
    chk("post_rst_gid", grant_id, 0);
    drain();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
    end
    drain();

`ifdef ARB_STATS_EN
    req_valid = 4'b0010;
    cnt = 0;
    while (mstat[1] < 65535 && cnt < 90000) begin
      step();
      cnt++;
    end
    repeat (400) step();
    drain();
    chk("stat_sat", stat_beats[31:16], 16'hFFFF);
    chk("stat_others", {stat_beats[63:32], stat_beats[15:0]},
        {16'(mstat[3]), 16'(mstat[2]), 16'(mstat[0])});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter

`default_nettype wire
